// File: rtl/ctrl_cnt_pkg.sv
// Shared definitions for the nested done-counter: width helper, count type and level limit.
package ctrl_cnt_pkg;

  localparam int N_LVL_MAX = 4;
  localparam int MNO_DEF   = 288;

  function automatic int cnt_width(input int mno);
    return $clog2(mno + 1);
  endfunction

  localparam int CW = cnt_width(MNO_DEF);

  typedef logic [CW-1:0] cnt_t;

endpackage

// File: rtl/ctrl_cnt_lvl.sv
// One level of the nested counter: a 1-based count that wraps at its loaded maximum.
module ctrl_cnt_lvl
  import ctrl_cnt_pkg::*;
#(
  parameter int W = CW
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         load,
  input  logic         advance,
  input  logic [W-1:0] max_val,
  output logic [W-1:0] count,
  output logic         at_max,
  output logic         at_max_m1
);

  logic [W-1:0] c;
  logic [W-1:0] m;

  // A loaded maximum of 0 is stored as 1 so the level always has a legal range.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c <= W'(1);
      m <= W'(1);
    end else if (clear) begin
      c <= W'(1);
    end else if (load) begin
      m <= (max_val == '0) ? W'(1) : max_val;
      c <= W'(1);
    end else if (advance) begin
      c <= (c == m) ? W'(1) : c + W'(1);
    end
  end

  assign count     = c;
  assign at_max    = (c == m);
  assign at_max_m1 = (m != W'(1)) && (c == m - W'(1));

endmodule

// File: rtl/ctrl_cnt_nest.sv
// Nested done-counter: carry chain across levels, end-of-layer saturation and overrun flag.
module ctrl_cnt_nest
  import ctrl_cnt_pkg::*;
#(
  parameter int  MNO      = 288,
  parameter int  N_LVL    = 3,
  parameter int  SAT_MODE = 0,
  localparam int CNT_W    = cnt_width(MNO)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   valid_ac3,
  input  logic                   cnt_load,
  input  logic                   cnt_clear,
  input  logic [N_LVL*CNT_W-1:0] max_val,
  output logic [N_LVL*CNT_W-1:0] cnt,
  output logic [N_LVL-1:0]       last_fil,
  output logic [N_LVL-1:0]       done_ac3,
  output logic                   all_done,
  output logic                   ovf
);

  logic [N_LVL-1:0] adv;
  logic [N_LVL-1:0] at_max;
  logic [N_LVL-1:0] at_max_m1;
  logic             beat;
  logic             hold;

  // Clear and load both swallow a coincident beat.
  assign beat   = valid_ac3 & ~cnt_clear & ~cnt_load;
  assign hold   = (SAT_MODE != 0) && all_done;
  assign adv[0] = beat & ~hold;

  genvar i;
  generate
    for (i = 1; i < N_LVL; i++) begin : g_carry
      assign adv[i] = adv[i-1] & at_max[i-1];
    end

    for (i = 0; i < N_LVL; i++) begin : g_lvl
      ctrl_cnt_lvl #(.W(CNT_W)) u_lvl (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (cnt_clear),
        .load     (cnt_load),
        .advance  (adv[i]),
        .max_val  (max_val[i*CNT_W +: CNT_W]),
        .count    (cnt[i*CNT_W +: CNT_W]),
        .at_max   (at_max[i]),
        .at_max_m1(at_max_m1[i])
      );
    end
  endgenerate

  assign done_ac3 = at_max;
  assign last_fil = at_max_m1;
  assign all_done = &at_max;

  // Overrun is sticky until the layer is restarted by clear, load or reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (cnt_clear || cnt_load) begin
      ovf <= 1'b0;
    end else if (beat && hold) begin
      ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ctrl_cnt_nest.sv
// Scoreboard bench: wrap and saturating instances share stimulus, checked against a layer-position model.
module tb_ctrl_cnt_nest;

  localparam int CW = 9;
  localparam int NL = 3;

  typedef struct packed {
    logic [NL*CW-1:0] cnt;
    logic [NL-1:0]    last;
    logic [NL-1:0]    done;
    logic             all;
    logic             ovf;
  } exp_t;

  typedef struct packed {
    exp_t w;
    exp_t s;
  } pair_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             valid_ac3 = 1'b0;
  logic             cnt_load = 1'b0;
  logic             cnt_clear = 1'b0;
  logic [NL*CW-1:0] max_val = '0;

  logic [NL*CW-1:0] cnt_w, cnt_s;
  logic [NL-1:0]    last_w, last_s, done_w, done_s;
  logic             all_w, all_s, ovf_w, ovf_s;

  int    checks = 0;
  int    errors = 0;
  pair_t exp_q[$];
  pair_t e;

  int   m_mod[NL];
  int   p_wrap;
  int   p_sat;
  logic ovf_sat;

  always #5 clk = ~clk;

  ctrl_cnt_nest #(.MNO(288), .N_LVL(NL), .SAT_MODE(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .valid_ac3(valid_ac3), .cnt_load(cnt_load),
    .cnt_clear(cnt_clear), .max_val(max_val), .cnt(cnt_w), .last_fil(last_w),
    .done_ac3(done_w), .all_done(all_w), .ovf(ovf_w)
  );

  ctrl_cnt_nest #(.MNO(288), .N_LVL(NL), .SAT_MODE(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .valid_ac3(valid_ac3), .cnt_load(cnt_load),
    .cnt_clear(cnt_clear), .max_val(max_val), .cnt(cnt_s), .last_fil(last_s),
    .done_ac3(done_s), .all_done(all_s), .ovf(ovf_s)
  );

  // Counts are the mixed-radix digits of the beat position within the layer.
  function automatic exp_t make_exp(input int p, input logic ov);
    exp_t r;
    int   div;
    int   c;
    r   = '0;
    div = 1;
    for (int i = 0; i < NL; i++) begin
      c = (p / div) % m_mod[i] + 1;
      div = div * m_mod[i];
      r.cnt[i*CW +: CW] = CW'(c);
      r.done[i] = (c == m_mod[i]);
      r.last[i] = (m_mod[i] >= 2) && (c == m_mod[i] - 1);
    end
    r.all = (p == div - 1);
    r.ovf = ov;
    return r;
  endfunction

  function automatic int layer_len();
    int n;
    n = 1;
    for (int i = 0; i < NL; i++) n = n * m_mod[i];
    return n;
  endfunction

  task automatic checkOutput(input string name, input logic [NL*CW-1:0] act,
                             input logic [NL*CW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic cl, input logic ld,
                               input logic v, input int a0, input int a1, input int a2);
    pair_t pr;
    @(negedge clk);
    rst_n     = r;
    cnt_clear = cl;
    cnt_load  = ld;
    valid_ac3 = v;
    max_val   = {CW'(a2), CW'(a1), CW'(a0)};
    if (!r) begin
      for (int i = 0; i < NL; i++) m_mod[i] = 1;
      p_wrap = 0; p_sat = 0; ovf_sat = 1'b0;
    end else if (cl) begin
      p_wrap = 0; p_sat = 0; ovf_sat = 1'b0;
    end else if (ld) begin
      m_mod[0] = (a0 < 1) ? 1 : a0;
      m_mod[1] = (a1 < 1) ? 1 : a1;
      m_mod[2] = (a2 < 1) ? 1 : a2;
      p_wrap = 0; p_sat = 0; ovf_sat = 1'b0;
    end else if (v) begin
      p_wrap = (p_wrap == layer_len() - 1) ? 0 : p_wrap + 1;
      if (p_sat == layer_len() - 1) ovf_sat = 1'b1;
      else p_sat = p_sat + 1;
    end
    pr.w = make_exp(p_wrap, 1'b0);
    pr.s = make_exp(p_sat, ovf_sat);
    exp_q.push_back(pr);
  endtask

  task automatic beats(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 0);
  endtask

  task automatic load(input int a0, input int a1, input int a2);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, a0, a1, a2);
  endtask

  // Monitor: every cycle after a drive the DUTs present a new state to compare.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("w_cnt",  cnt_w,                e.w.cnt);
      checkOutput("w_last", {24'd0, last_w},      {24'd0, e.w.last});
      checkOutput("w_done", {24'd0, done_w},      {24'd0, e.w.done});
      checkOutput("w_all",  {26'd0, all_w},       {26'd0, e.w.all});
      checkOutput("w_ovf",  {26'd0, ovf_w},       {26'd0, e.w.ovf});
      checkOutput("s_cnt",  cnt_s,                e.s.cnt);
      checkOutput("s_last", {24'd0, last_s},      {24'd0, e.s.last});
      checkOutput("s_done", {24'd0, done_s},      {24'd0, e.s.done});
      checkOutput("s_all",  {26'd0, all_s},       {26'd0, e.s.all});
      checkOutput("s_ovf",  {26'd0, ovf_s},       {26'd0, e.s.ovf});
    end
  end

  initial begin
    int r;
    int mv0, mv1, mv2;
    for (int i = 0; i < NL; i++) m_mod[i] = 1;
    p_wrap = 0; p_sat = 0; ovf_sat = 1'b0;

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);

    load(3, 2, 2);
    beats(12);

    load(2, 2, 1);
    beats(5);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0);

    load(0, 1, 4);
    beats(6);

    load(3, 3, 3);
    beats(1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4, 2, 2);
    beats(2);

    load(3, 3, 3);
    beats(2);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 5, 5, 5);
    beats(9);

    beats(4);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);

    for (int k = 0; k < 600; k++) begin
      r   = int'($urandom_range(0, 99));
      mv0 = int'($urandom_range(0, 5));
      mv1 = int'($urandom_range(0, 4));
      mv2 = int'($urandom_range(0, 3));
      applyStimulus((r >= 2) ? 1'b1 : 1'b0,
                    (r >= 2 && r < 5) ? 1'b1 : 1'b0,
                    (r >= 5 && r < 10) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 99) < 80) ? 1'b1 : 1'b0,
                    mv0, mv1, mv2);
    end

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    repeat (4) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ctrl_cnt_nest.md
# ctrl_cnt_nest

Programmable nested done-counter for the datapath controller, successor to the single-level AC3 done counter. It counts `valid_ac3` beats across `N_LVL` nested loop levels (e.g. filter → channel → convolutional volume). Each level has its own run-time max, loaded once per layer. Per-level `last`/`done` flags drive FSM transitions, and an optional saturating mode flags beat overruns at end of layer.

## Interface
Parameters:
- `MNO`, 288: largest programmable max of any level; counter width `CW = $clog2(MNO+1)`.
- `N_LVL`, 3: number of nested levels; level 0 is innermost. Legal range 1..4.
- `SAT_MODE`, 0: 0 = wrap at end of layer; 1 = hold at end of layer and flag overrun.

Ports (`clk`, `rst_n` first):
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `valid_ac3`  in  1  one count beat per cycle high.
- `cnt_load`  in  1  latch `max_val` and restart all counts.
- `cnt_clear`  in  1  restart all counts; keep loaded maxima.
- `max_val`  in  N_LVL×CW  per-level max, packed with level 0 in the LSBs.
- `cnt`  out  N_LVL×CW  current 1-based count per level.
- `last_fil`  out  N_LVL  level i count == max_i−1 (one beat before done).
- `done_ac3`  out  N_LVL  level i count == max_i.
- `all_done`  out  1  all levels at max; final beat of layer reached.
- `ovf`  out  1  sticky; beat received while `all_done` with `SAT_MODE`=1.

## Operation
- State per level:
  - count `c_i`, range 1..m_i
  - max register `m_i`
- Effective max: `m_i = max(max_val_i, 1)`. A loaded 0 is stored as 1.
- Priority each cycle: `rst_n`=0 > `cnt_clear` > `cnt_load` > `valid_ac3`.
- Reset:
  - all `c_i`=1 and all `m_i`=1
  - `ovf`=0
  - with all maxima at 1, `done_ac3` and `all_done` read 1 after reset; `last_fil` and `cnt` follow the flag rules below
- `cnt_clear`: all `c_i`=1, `ovf`=0, maxima unchanged.
- `cnt_load`: all `m_i` ← effective `max_val_i`, all `c_i`=1, `ovf`=0. A `valid_ac3` in the same cycle is dropped.
- Beat (`valid_ac3`=1, no clear/load):
  - level 0 always advances
  - level i>0 advances only if every level below it is at its max (carry)
  - advancing level at max wraps to 1, otherwise increments by 1
- End of layer (`all_done`=1) plus a beat:
  - `SAT_MODE`=0: every level wraps to 1 and the next layer pass starts
  - `SAT_MODE`=1: counts hold and `ovf` sets, staying set until clear, load or reset
- Flags are pure decodes of the registered `c_i`/`m_i`, aligned with `cnt` in the same cycle:
  - `done_ac3[i] = (c_i == m_i)`
  - `last_fil[i] = (m_i ≥ 2) && (c_i == m_i−1)`
  - `all_done` = AND of all `done_ac3`
- `max_val` > MNO is out of contract and is not checked.

## Timing
- Count latency: a beat in cycle t updates `cnt` and the flags visible in cycle t+1.
- Clear, load and reset are likewise visible one cycle after being sampled.
- No handshake back-pressure: a beat is accepted every cycle `valid_ac3`=1.
- No combinational path from any input to any output; outputs depend only on registers.
- Back-to-back beats advance one step per cycle. Carry ripples through all levels in the same cycle.

## Structure
- Shared package `ctrl_cnt_pkg`:
  - `CW` helper function
  - typedef `cnt_t` = `logic [CW-1:0]`
  - `N_LVL_MAX` = 4
- Sub-module `ctrl_cnt_lvl`, one per level via generate:
  - inputs: clear, load, advance, max
  - outputs: count, at_max, at_max_m1
- Top level holds the carry chain, the saturation/`ovf` logic and the output packing.

## Test plan
- Reset, then load maxima {3,2,2} (levels 0,1,2) and send 12 beats:
  - level 0 cycles 1,2,3; level 1 advances on every third beat; `all_done` high after beat 11
  - with `SAT_MODE`=0, beat 12 returns all counts to {1,1,1}
- `SAT_MODE`=1, maxima {2,2,1}, 5 beats:
  - after beat 3, `all_done`=1
  - beats 4–5 hold counts at {2,2,1} and set `ovf`; `cnt_clear` drops `ovf`
- Load maxima {0,1,4} → stored as {1,1,4}:
  - `done_ac3`[0] and [1] are constant 1; `last_fil`[0]=0
  - level 2 advances on every beat, with `last_fil`[2]=1 at count 3
- `cnt_load` and `valid_ac3` in the same cycle with counts {2,1,1} → counts {1,1,1}, new maxima, beat ignored.
- `cnt_clear` together with `cnt_load` (new maxima {5,5,5}) while maxima are {3,3,3] → counts {1,1,1} and maxima stay {3,3,3}.
- `rst_n`=0 for one cycle mid-count, with `valid_ac3` high and `clk` running → next cycle counts {1,1,1}, maxima {1,1,1}, `ovf`=0, `all_done`=1.
